// File: rtl/nibble_add_arbiter_pkg.sv
// nibble_add_arbiter_pkg
//   Shared definitions for the slice-serial two-requester adder:
//   FSM state encoding, default geometry and the derived slice count.
package nibble_add_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W_DEF  = 16;
    localparam int SLICE_W_DEF = 4;
    localparam int NSLICES     = WORD_W_DEF / SLICE_W_DEF;

    // Slice count for an arbitrary geometry (WORD_W a multiple of SLICE_W).
    function automatic int nslices(input int word_w, input int slice_w);
        return word_w / slice_w;
    endfunction

    // Counter width able to index n slices; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_arbiter_add_slice.sv
// add_slice
//   Purely combinational SLICE_W-bit ripple-carry adder built from
//   full-adder cells.
//   Ports: a, b  - slice operands
//          ci    - carry in
//          s     - slice sum
//          co    - carry out of the top cell
module add_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_add_arbiter.sv
// nibble_add_arbiter
//   Two requesters share a single SLICE_W-bit adder. An accepted operation
//   is added one slice per cycle, LSB slice first, and the result is held
//   until the consumer takes it. Ties between requesters are broken by a
//   round-robin pointer that always favours the one not served last.
//   Ports: clk, rst_n                   - clock, async active-low reset
//          reqN_valid/ready              - requester N handshake
//          reqN_a, reqN_b, reqN_cin      - requester N operands
//          rsp_valid/ready               - result handshake
//          rsp_id, rsp_sum, rsp_cout     - result owner, sum, carry-out
//          busy                          - operation in RUN or DONE
module nibble_add_arbiter
    import nibble_add_arbiter_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WORD_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              busy
);

    localparam int NSL = nslices(WORD_W, SLICE_W);
    localparam int KW  = cnt_w(NSL);

    state_t              state;
    logic [KW-1:0]       k;
    logic [WORD_W-1:0]   a_q, b_q, sum_q;
    logic                carry_q, cout_q, id_q, rr_ptr;

    logic                any_req, grant, accept;
    logic [SLICE_W-1:0]  a_sl, b_sl, s_sl;
    logic                co_sl;

    // Single valid requester wins outright; on a tie the pointer decides.
    always_comb begin
        any_req = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) grant = rr_ptr;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && any_req && !grant;
    assign req1_ready = (state == IDLE) && any_req &&  grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign a_sl = a_q[k*SLICE_W +: SLICE_W];
    assign b_sl = b_q[k*SLICE_W +: SLICE_W];

    add_slice #(.SLICE_W(SLICE_W)) u_add (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry_q),
        .s  (s_sl),
        .co (co_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= grant ? req1_a   : req0_a;
                        b_q     <= grant ? req1_b   : req0_b;
                        carry_q <= grant ? req1_cin : req0_cin;
                        id_q    <= grant;
                        rr_ptr  <= ~grant;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[k*SLICE_W +: SLICE_W] <= s_sl;
                    carry_q <= co_sl;
                    if (k == KW'(NSL - 1)) begin
                        // Last slice: its carry is the word carry-out.
                        cout_q <= co_sl;
                        k      <= '0;
                        state  <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule

// File: doc/nibble_add_arbiter.md
NIBBLE_ADD_ARBITER -- requirements
Module: nibble_add_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE_W, default 4, giving the adder slice width per cycle; WORD_W SHALL be an integer multiple of SLICE_W.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port `clk` (input, 1 bit, rising-edge clock) and port `rst_n` (input, 1 bit, asynchronous active-low reset).
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- `req0_valid`, in, 1, requester 0 has an operation.
- `req0_ready`, out, 1, requester 0 operation accepted this cycle.
- `req0_a`, in, WORD_W, requester 0 operand A.
- `req0_b`, in, WORD_W, requester 0 operand B.
- `req0_cin`, in, 1, requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same directions, widths and meanings for requester 1.
- `rsp_valid`, out, 1, result available.
- `rsp_ready`, in, 1, consumer takes the result.
- `rsp_id`, out, 1, index of the requester that owns the result.
- `rsp_sum`, out, WORD_W, the sum.
- `rsp_cout`, out, 1, final carry-out.
- `busy`, out, 1, an operation is in flight (RUN or DONE).

Function
REQ-005 The block SHALL time-share one SLICE_W-bit ripple adder between two requesters, adding one SLICE_W slice per cycle, LSB slice first.
REQ-006 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-007 In IDLE, a grant SHALL go to the single valid requester; if both are valid, it SHALL go to the requester named by the round-robin pointer `rr_ptr`.
REQ-008 `reqN_ready` SHALL equal (state==IDLE) AND (grant==N), combinationally; at most one ready SHALL be high per cycle.
REQ-009 On a valid&&ready edge the block SHALL:
- latch A, B, cin and id;
- clear slice counter k to 0;
- set `rr_ptr` to the other requester;
- enter RUN.
REQ-010 In each RUN cycle the block SHALL:
- compute the sum of slice k of A, slice k of B and the held carry;
- write the SLICE_W sum bits into slice k of the sum register;
- update the held carry;
- increment k.
REQ-011 On the edge that processes the last slice (k = WORD_W/SLICE_W-1) the block SHALL enter DONE.
REQ-012 Latency SHALL be exactly WORD_W/SLICE_W cycles: `rsp_valid` rises WORD_W/SLICE_W rising edges after the accept edge (4 for default parameters).
REQ-013 In DONE, `rsp_valid` SHALL be 1 and `rsp_sum`, `rsp_cout` and `rsp_id` SHALL be stable until `rsp_valid`&&`rsp_ready`; on that edge the block SHALL return to IDLE.
REQ-014 No request SHALL be accepted in RUN or DONE, including the DONE-handshake cycle; the earliest next accept SHALL be the first IDLE cycle.
REQ-015 Arithmetic SHALL be modulo 2^WORD_W, with `rsp_cout` equal to bit WORD_W of A+B+cin; wrap-around SHALL be reported only via `rsp_cout`.
REQ-016 `rsp_sum` and `rsp_cout` SHALL show the register contents in all states; their values SHALL be meaningful only while `rsp_valid`=1.
REQ-017 `busy` SHALL be 1 exactly when state is RUN or DONE.
REQ-018 Requester inputs SHALL be ignored outside the accept edge; a requester that drops valid before being granted SHALL lose no state and SHALL produce no response.

Reset
REQ-019 While `rst_n`=0, asynchronously, the block SHALL force the following, aborting any operation in flight with no response emitted:
- state=IDLE;
- k=0;
- held carry=0;
- sum register=0;
- `rsp_cout`=0;
- `rsp_id`=0;
- `rr_ptr`=0 (requester 0 favoured);
- `rsp_valid`=0 and `busy`=0.
REQ-020 The first accept SHALL be possible on the first rising edge with `rst_n`=1.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the derived constant NSLICES = WORD_W/SLICE_W.
REQ-022 The single slice adder SHALL be a sub-module `add_slice` (SLICE_W-bit ripple of full-adder cells, purely combinational), instantiated exactly once.

Verification
REQ-023 The bench SHALL cover, at minimum:
- Single op: req0 A=0x1234, B=0x1111, cin=0 → `rsp_valid` exactly 4 cycles after accept, sum=0x2345, cout=0, id=0.
- Wrap-around: req1 A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, cout=1, id=1; A=0xFFFF, B=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- Contention: both valid continuously from reset → grants alternate 0,1,0,1; no ready while busy; each response matches its owner's operands.
- Back-pressure: `rsp_ready` held low 10 cycles in DONE → `rsp_valid`, sum and id stable; no new ready; IDLE one cycle after the handshake.
- Reset mid-op: `rst_n` pulsed low during RUN at k=2 → all outputs at reset values immediately; no response; next accept goes to req0.
- Parameter sweep: WORD_W=8, SLICE_W=4 and WORD_W=32, SLICE_W=8 → latency equals NSLICES; random sums match reference addition over 10k ops.
